// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch port, data port and unified memory port.
// The arbiter takes the slave view; the core/memory environment takes master.
interface mem_arbiter_if;
  logic        f_req_valid;
  logic        f_req_ready;
  logic [31:0] f_addr;
  logic        f_rsp_valid;
  logic [31:0] f_rdata;

  logic        d_req_valid;
  logic        d_req_ready;
  logic [31:0] d_addr;
  logic        d_we;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_rsp_valid;
  logic [31:0] d_rdata;

  logic        mem_req;
  logic        mem_gnt;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport slave (
    input  f_req_valid, f_addr,
    output f_req_ready, f_rsp_valid, f_rdata,
    input  d_req_valid, d_addr, d_we, d_wdata, d_wstrb,
    output d_req_ready, d_rsp_valid, d_rdata,
    output mem_req, mem_addr, mem_we, mem_wdata, mem_wstrb,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport master (
    output f_req_valid, f_addr,
    input  f_req_ready, f_rsp_valid, f_rdata,
    output d_req_valid, d_addr, d_we, d_wdata, d_wstrb,
    input  d_req_ready, d_rsp_valid, d_rdata,
    input  mem_req, mem_addr, mem_we, mem_wdata, mem_wstrb,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/LSU arbiter onto a single-port unified memory, one txn in flight.
// Define STARVE_GUARD_EN to let fetch win after MAX_WAIT lost arbitrations.
module mem_arbiter #(
  parameter int unsigned MAX_WAIT = 4
) (
  input logic         clk,
  input logic         reset,
  mem_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam logic OWN_F = 1'b0;
  localparam logic OWN_D = 1'b1;

  if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
    $error("mem_arbiter: MAX_WAIT must be in 1..255");
  end

  logic [1:0]  state_q, state_d;
  logic        owner_q, owner_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        f_rsp_q, f_rsp_d;
  logic        d_rsp_q, d_rsp_d;
  logic [31:0] f_rdata_q, f_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        sel_d;
  logic        any_req;
  logic        grant;

  assign any_req = bus.f_req_valid | bus.d_req_valid;

`ifdef STARVE_GUARD_EN
  localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

  logic [7:0] starve_q, starve_d;

  // Fetch overrides data once it has lost MAX_WAIT times in a row.
  always_comb begin
    sel_d = bus.d_req_valid;
    if (bus.f_req_valid && starve_q == MaxWait)
      sel_d = 1'b0;
  end

  always_comb begin
    starve_d = starve_q;
    if (state_q == S_IDLE && any_req) begin
      if (!sel_d)
        starve_d = '0;
      else if (bus.f_req_valid && starve_q != MaxWait)
        starve_d = starve_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end
`else
  always_comb sel_d = bus.d_req_valid;
`endif

  assign bus.mem_req   = (state_q == S_ISSUE);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wstrb = wstrb_q;

  assign grant           = bus.mem_req & bus.mem_gnt;
  assign bus.f_req_ready = grant & (owner_q == OWN_F);
  assign bus.d_req_ready = grant & (owner_q == OWN_D);

  assign bus.f_rsp_valid = f_rsp_q;
  assign bus.d_rsp_valid = d_rsp_q;
  assign bus.f_rdata     = f_rdata_q;
  assign bus.d_rdata     = d_rdata_q;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    f_rsp_d   = 1'b0;
    d_rsp_d   = 1'b0;
    f_rdata_d = f_rdata_q;
    d_rdata_d = d_rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d = S_ISSUE;
          if (sel_d) begin
            owner_d = OWN_D;
            addr_d  = bus.d_addr;
            we_d    = bus.d_we;
            wdata_d = bus.d_wdata;
            wstrb_d = bus.d_wstrb;
          end else begin
            owner_d = OWN_F;
            addr_d  = bus.f_addr;
            we_d    = 1'b0;
            wdata_d = '0;
            wstrb_d = '0;
          end
        end
      end
      S_ISSUE: begin
        if (bus.mem_gnt)
          state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.mem_rvalid) begin
          state_d = S_IDLE;
          if (owner_q == OWN_D) begin
            d_rsp_d   = 1'b1;
            d_rdata_d = bus.mem_rdata;
          end else begin
            f_rsp_d   = 1'b1;
            f_rdata_d = bus.mem_rdata;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      owner_q   <= OWN_F;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      f_rsp_q   <= 1'b0;
      d_rsp_q   <= 1'b0;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      f_rsp_q   <= f_rsp_d;
      d_rsp_q   <= d_rsp_d;
      f_rdata_q <= f_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: memory model, response scoreboard
// and one task per scenario.
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(.MAX_WAIT(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] f_exp_q[$];
  logic [31:0] d_exp_q[$];
  int          d_rsp_cyc_q[$];
  int          f_rsp_cyc = -1;
  int          f_rdy_cnt = 0;
  int          d_rdy_cnt = 0;
  logic [31:0] mon_e;

  int   gnt_delay = 0;
  int   rv_delay = 0;
  logic model_flush = 1'b0;
  logic stale_rv = 1'b0;
  logic        pend = 1'b0;
  logic [31:0] paddr = '0;
  int          wcnt = 0;
  int          rcnt = 0;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'h0050_0093;
  endfunction

  // Memory model: updates its outputs 2ns after each rising edge.
  initial begin
    bus.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      bus.mem_rvalid = 1'b0;
      if (model_flush) begin
        pend = 1'b0;
        wcnt = 0;
        rcnt = 0;
      end
      if (stale_rv) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata = 32'hBAD0_BAD0;
      end else if (pend) begin
        if (rcnt >= rv_delay) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata = mdata(paddr);
          pend = 1'b0;
          rcnt = 0;
        end else begin
          rcnt++;
        end
      end
      bus.mem_gnt = 1'b0;
      if (bus.mem_req && !model_flush) begin
        if (wcnt >= gnt_delay) begin
          bus.mem_gnt = 1'b1;
          pend = 1'b1;
          paddr = bus.mem_addr;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end
    end
  end

  // Response scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.f_req_ready) f_rdy_cnt++;
      if (bus.d_req_ready) d_rdy_cnt++;
      if (bus.f_rsp_valid) begin
        checks++;
        f_rsp_cyc = cyc;
        if (f_exp_q.size() == 0) begin
          errors++;
          $display("FAIL f_rsp_unexpected: f_rdata=%h, required no response", bus.f_rdata);
        end else begin
          mon_e = f_exp_q.pop_front();
          if (bus.f_rdata !== mon_e) begin
            errors++;
            $display("FAIL f_rdata: got %h, required %h", bus.f_rdata, mon_e);
          end
        end
      end
      if (bus.d_rsp_valid) begin
        checks++;
        d_rsp_cyc_q.push_back(cyc);
        if (d_exp_q.size() == 0) begin
          errors++;
          $display("FAIL d_rsp_unexpected: d_rdata=%h, required no response", bus.d_rdata);
        end else begin
          mon_e = d_exp_q.pop_front();
          if (bus.d_rdata !== mon_e) begin
            errors++;
            $display("FAIL d_rdata: got %h, required %h", bus.d_rdata, mon_e);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at posedge+1; returns at posedge+1 with the request dropped.
  task automatic do_req(input bit is_d, input logic [31:0] a, input bit we,
                        input logic [31:0] wd, input logic [3:0] ws,
                        output int t0, output int t_rdy);
    t0 = cyc;
    t_rdy = -1;
    if (is_d) begin
      bus.d_req_valid = 1'b1;
      bus.d_addr = a;
      bus.d_we = we;
      bus.d_wdata = wd;
      bus.d_wstrb = ws;
      d_exp_q.push_back(mdata(a));
    end else begin
      bus.f_req_valid = 1'b1;
      bus.f_addr = a;
      f_exp_q.push_back(mdata(a));
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (is_d ? bus.d_req_ready : bus.f_req_ready) begin
        t_rdy = cyc;
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    bus.d_req_valid = 1'b0;
    bus.f_req_valid = 1'b0;
    checks++;
    if (t_rdy < 0) begin
      errors++;
      $display("FAIL req_ready_timeout: addr=%h got no ready, required ready", a);
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 40 && (f_exp_q.size() != 0 || d_exp_q.size() != 0); i++)
      @(posedge clk);
    #1;
    checks++;
    if (f_exp_q.size() != 0 || d_exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: pending f=%0d d=%0d, required 0 0",
               name, f_exp_q.size(), d_exp_q.size());
      f_exp_q.delete();
      d_exp_q.delete();
    end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_wstrb, bus.mem_addr, bus.mem_wdata} !== '0) begin
      errors++;
      $display("FAIL %s_mem: req=%b we=%b strb=%h addr=%h wdata=%h, required all 0", name,
               bus.mem_req, bus.mem_we, bus.mem_wstrb, bus.mem_addr, bus.mem_wdata);
    end
    checks++;
    if ({bus.f_rsp_valid, bus.d_rsp_valid, bus.f_rdata, bus.d_rdata,
         bus.f_req_ready, bus.d_req_ready} !== '0) begin
      errors++;
      $display("FAIL %s_core: frv=%b drv=%b frd=%h drd=%h frdy=%b drdy=%b, required all 0",
               name, bus.f_rsp_valid, bus.d_rsp_valid, bus.f_rdata, bus.d_rdata,
               bus.f_req_ready, bus.d_req_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.f_req_valid = 1'b0;
    bus.f_addr = '0;
    bus.d_req_valid = 1'b0;
    bus.d_addr = '0;
    bus.d_we = 1'b0;
    bus.d_wdata = '0;
    bus.d_wstrb = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk);
    #1;
  endtask

  task automatic test_fetch();
    int t0, tr, d0;
    d0 = d_rdy_cnt;
    d_rsp_cyc_q.delete();
    do_req(1'b0, 32'h0, 1'b0, '0, '0, t0, tr);
    wait_drain("fetch");
    checks++;
    if (tr - t0 !== 1) begin
      errors++;
      $display("FAIL fetch_ready_lat: got %0d, required 1", tr - t0);
    end
    checks++;
    if (f_rsp_cyc - t0 !== 3) begin
      errors++;
      $display("FAIL fetch_rsp_lat: got %0d, required 3", f_rsp_cyc - t0);
    end
    checks++;
    if (bus.f_rdata !== 32'h0050_0093) begin
      errors++;
      $display("FAIL fetch_rdata_hold: got %h, required 00500093", bus.f_rdata);
    end
    checks++;
    if (d_rdy_cnt != d0 || d_rsp_cyc_q.size() != 0 || bus.d_rdata !== '0) begin
      errors++;
      $display("FAIL fetch_d_quiet: rdy=%0d rsp=%0d rdata=%h, required 0 0 0",
               d_rdy_cnt - d0, d_rsp_cyc_q.size(), bus.d_rdata);
    end
  endtask

  task automatic test_store();
    int t0, tr, d0, req_cyc;
    req_cyc = 0;
    gnt_delay = 2;
    d0 = d_rdy_cnt;
    d_rsp_cyc_q.delete();
    fork
      do_req(1'b1, 32'h100, 1'b1, 32'hDEAD_BEEF, 4'hF, t0, tr);
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (bus.mem_req) begin
          req_cyc++;
          checks++;
          if ({bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.mem_wstrb} !==
              {32'h100, 1'b1, 32'hDEAD_BEEF, 4'hF}) begin
            errors++;
            $display("FAIL store_fields: addr=%h we=%b wdata=%h strb=%h, required 100 1 deadbeef f",
                     bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.mem_wstrb);
          end
        end
      end
    join
    wait_drain("store");
    gnt_delay = 0;
    checks++;
    if (req_cyc != 3) begin
      errors++;
      $display("FAIL store_req_cycles: got %0d, required 3", req_cyc);
    end
    checks++;
    if (d_rdy_cnt - d0 != 1) begin
      errors++;
      $display("FAIL store_ready_pulses: got %0d, required 1", d_rdy_cnt - d0);
    end
    checks++;
    if (d_rsp_cyc_q.size() != 1 || d_rsp_cyc_q[0] - t0 != 5) begin
      errors++;
      $display("FAIL store_rsp_lat: n=%0d lat=%0d, required 1 5", d_rsp_cyc_q.size(),
               d_rsp_cyc_q.size() != 0 ? d_rsp_cyc_q[0] - t0 : -1);
    end
  endtask

  task automatic test_back_to_back();
    int t0, ta, tr;
    d_rsp_cyc_q.delete();
    do_req(1'b1, 32'h0, 1'b0, '0, '0, t0, tr);
    do_req(1'b1, 32'h4, 1'b0, '0, '0, ta, tr);
    do_req(1'b1, 32'h8, 1'b0, '0, '0, ta, tr);
    wait_drain("b2b");
    checks++;
    if (d_rsp_cyc_q.size() != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d, required 3", d_rsp_cyc_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (d_rsp_cyc_q[i] - t0 != 3 * (i + 1)) begin
          errors++;
          $display("FAIL b2b_cycle%0d: got %0d, required %0d", i,
                   d_rsp_cyc_q[i] - t0, 3 * (i + 1));
        end
      end
    end
  endtask

  task automatic test_starve();
    string exp_s;
    byte   got[10];
    int    n;
    n = 0;
`ifdef STARVE_GUARD_EN
    exp_s = "DDDDFDDDDF";
`else
    exp_s = "DDDDDDDDDD";
`endif
    bus.f_req_valid = 1'b1;
    bus.f_addr = 32'h200;
    bus.d_req_valid = 1'b1;
    bus.d_addr = 32'h300;
    bus.d_we = 1'b0;
    bus.d_wdata = '0;
    bus.d_wstrb = '0;
    for (int i = 0; i < 80 && n < 10; i++) begin
      @(negedge clk);
      if (bus.f_req_ready && n < 10) begin
        got[n] = "F";
        n++;
        f_exp_q.push_back(mdata(32'h200));
      end
      if (bus.d_req_ready && n < 10) begin
        got[n] = "D";
        n++;
        d_exp_q.push_back(mdata(32'h300));
      end
    end
    @(posedge clk);
    #1;
    bus.f_req_valid = 1'b0;
    bus.d_req_valid = 1'b0;
    wait_drain("starve");
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (i >= n || got[i] != exp_s[i]) begin
        errors++;
        $display("FAIL starve_grant%0d: got %s, required %s", i,
                 i < n ? string'(got[i]) : "none", string'(exp_s[i]));
      end
    end
  endtask

  task automatic test_reset_mid();
    int t0, tr;
    rv_delay = 5;
    do_req(1'b1, 32'h40, 1'b0, '0, '0, t0, tr);
    reset = 1'b1;
    model_flush = 1'b1;
    d_exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    model_flush = 1'b0;
    rv_delay = 0;
    stale_rv = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_idle_outputs("rst_mid");
      @(posedge clk);
      #1;
      stale_rv = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_back_to_back();
    test_starve();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the core's single-port unified memory between the instruction-fetch path and the load/store data path. The block sequences one transaction at a time:
- arbitrate between the two requesters;
- issue the winner to memory and hold it until memory accepts;
- wait for the read/ack beat and route the response back to the owner.

It sits between the fetch/LSU logic of the core and the memory model. It replaces the separate instruction and data memories once the design moves to a unified memory.

## Interface
Parameters:
- MAX_WAIT, 4: fetch-starvation threshold in lost arbitrations (only used with STARVE_GUARD_EN); legal range 1..255.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- f_req_valid  in  1  fetch request pending
- f_req_ready  out  1  fetch request accepted this cycle
- f_addr  in  32  fetch byte address
- f_rsp_valid  out  1  fetch response strobe, one cycle
- f_rdata  out  32  fetched word
- d_req_valid  in  1  data request pending
- d_req_ready  out  1  data request accepted this cycle
- d_addr  in  32  data byte address
- d_we  in  1  1 = store, 0 = load
- d_wdata  in  32  store data
- d_wstrb  in  4  store byte enables
- d_rsp_valid  out  1  data response strobe (load data or store ack)
- d_rdata  out  32  load data
- mem_req  out  1  memory request
- mem_gnt  in  1  memory accepts request this cycle
- mem_addr  out  32  memory address
- mem_we  out  1  memory write
- mem_wdata  out  32  memory write data
- mem_wstrb  out  4  memory byte enables
- mem_rvalid  in  1  memory response beat
- mem_rdata  in  32  memory read data

## Operation
- FSM states: IDLE, ISSUE, WAIT. Owner register: F or D. At most one memory transaction is outstanding.
- **IDLE**
  - If any req_valid is set, choose a winner, latch its addr/we/wdata/wstrb into the mem_* registers and latch the owner. Go to ISSUE.
  - Fetch requests latch we=0 and wstrb=0.
  - With no request, stay in IDLE.
- **Priority:** data beats fetch when both are valid (starvation guard below can override).
- **ISSUE**
  - mem_req=1 and the mem_* fields are stable.
  - On mem_gnt, pulse the owner's req_ready in the same cycle (combinational from state, owner and mem_gnt), then go to WAIT.
  - Without mem_gnt, hold every field and stay in ISSUE.
- **WAIT**
  - mem_req=0.
  - On mem_rvalid, register mem_rdata into the owner's rdata and set the owner's rsp_valid for exactly the next cycle. Go to IDLE.
  - Stores also return an ack beat; d_rdata then takes mem_rdata unfiltered.
- mem_rvalid seen in IDLE or ISSUE is ignored. This covers stale beats after a reset.
- **Requester rule:** hold valid and fields until ready. A new request may be presented the cycle after ready. It is arbitrated only in IDLE.
- f_rdata/d_rdata hold their last value between strobes.

## Timing
- Reset values:
  - state=IDLE, owner=F, starvation counter=0.
  - mem_req=0, mem_addr=0, mem_we=0, mem_wdata=0, mem_wstrb=0.
  - f_rsp_valid=0, d_rsp_valid=0, f_rdata=0, d_rdata=0.
  - f_req_ready=0, d_req_ready=0.
- Reset mid-transaction drops the transaction. No response is ever produced for it.
- **Minimum latency:**
  - req_valid at cycle 0; mem_req at cycle 1.
  - req_ready at cycle 1 if mem_gnt.
  - mem_rvalid at cycle 2; rsp_valid at cycle 3.
  - The FSM is back in IDLE at cycle 3, so it can arbitrate again in the same cycle as rsp_valid.
- **Throughput:** one transaction per 3 cycles with zero memory wait states.
- Each mem_gnt wait cycle in ISSUE and each mem_rvalid wait cycle in WAIT adds one cycle.
- A request that arrives during ISSUE/WAIT waits; it is not lost.

## Configuration
- **STARVE_GUARD_EN defined:**
  - An 8-bit counter increments each time IDLE picks D while f_req_valid=1. It saturates at MAX_WAIT.
  - When counter==MAX_WAIT and both are valid, IDLE picks F.
  - The counter clears whenever F is granted (IDLE selects F).
- **Not defined:** strict data priority; the counter is absent; fetch may starve indefinitely.

## Test plan
- Single fetch, mem_gnt tied 1, mem_rvalid one cycle after gnt, mem_rdata=0x00500093 -> f_req_ready at cycle 1, f_rsp_valid for one cycle at cycle 3 with f_rdata=0x00500093; d_* outputs stay 0.
- Store d_addr=0x100, d_wdata=0xDEADBEEF, d_wstrb=0xF, mem_gnt delayed 2 cycles -> mem_req high for 3 cycles with fields stable; d_req_ready pulses once; d_rsp_valid follows one cycle after mem_rvalid.
- Fetch and load both valid, continuously re-requesting, macro off -> 10 consecutive D grants, zero F grants.
- Same stimulus with STARVE_GUARD_EN and MAX_WAIT=4 -> D,D,D,D,F,D,D,D,D,F grant order.
- Reset asserted in WAIT, then mem_rvalid=1 the cycle after reset releases -> no rsp_valid; FSM stays in IDLE; all outputs at reset values.
- Back-to-back loads from 0x0, 0x4, 0x8, zero wait states -> d_rsp_valid at cycles 3, 6, 9 with matching data, in order.
